// File: rtl/x_bufgmux_ce.sv
`default_nettype none
// ============================================================================
//  Module      : x_bufgmux_ce
//  Description : Clock-style 2:1 multiplexer sampled on CLK. In SYNC mode a
//                select change drains the old source to the idle level, parks
//                the output at that level, then waits for the new source to
//                reach the idle level before handing over. This way no short
//                pulse is ever produced. In ASYNC mode the select takes effect
//                on the next edge. SN is a plain inverter of S.
//  Revision    : 1.0 - initial release
// ============================================================================
module x_bufgmux_ce #(
  parameter logic [39:0] CLK_SEL_TYPE = 40'("SYNC"),
  parameter int          INIT_OUT     = 0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic I0,
  input  logic I1,
  input  logic S,
  output logic O,
  output logic SN
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [39:0] c_sync  = 40'("SYNC");
  localparam logic [39:0] c_async = 40'("ASYNC");

  // Idle level L: 0 behaves like BUFGMUX, 1 behaves like BUFGMUX_1.
  localparam logic c_idle     = (INIT_OUT != 0);
  localparam logic c_is_async = (CLK_SEL_TYPE == c_async);

  // State encoding
  localparam logic [1:0] c_st_sel0  = 2'd0; // following I0
  localparam logic [1:0] c_st_sel1  = 2'd1; // following I1
  localparam logic [1:0] c_st_drain = 2'd2; // old source still active
  localparam logic [1:0] c_st_arm   = 2'd3; // parked at L, waiting on new source

  // --------------------------------------------------------------------------
  // Attribute checking. A bad attribute stops elaboration outright so that a
  // mis-configured instance can never be simulated or built silently.
  // --------------------------------------------------------------------------
  generate
    if ((CLK_SEL_TYPE != c_sync) && (CLK_SEL_TYPE != c_async)) begin : g_bad_sel_type
      $fatal(1, "Attribute Syntax Error : CLK_SEL_TYPE on x_bufgmux_ce must be \"SYNC\" or \"ASYNC\".");
    end
    if ((INIT_OUT != 0) && (INIT_OUT != 1)) begin : g_bad_init_out
      $fatal(1, "Attribute Syntax Error : INIT_OUT on x_bufgmux_ce must be 0 or 1.");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic       r_c;      // current select: the source O is (or was) following
  logic       r_t;      // target select: the source O is switching towards
  logic       r_o;

  logic [1:0] w_state_nxt;
  logic       w_c_nxt;
  logic       w_t_nxt;
  logic       w_o_nxt;

  // Source views. Only the selected source is ever routed onto O, so an X on
  // the unselected input cannot leak through.
  logic w_ic;   // old source I(C)
  logic w_it;   // new source I(T)
  logic w_is;   // source named by the live select input
  logic w_sel_changed;
  logic w_tgt_changed;

  assign w_ic          = r_c ? I1 : I0;
  assign w_it          = r_t ? I1 : I0;
  assign w_is          = S   ? I1 : I0;
  assign w_sel_changed = (S != r_c);
  assign w_tgt_changed = (S != r_t);

  // Inverter function, independent of the clock and of reset.
  assign SN = ~S;

  assign O = r_o;

  // State register: synchronous active-low reset overrides any switch in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= c_st_sel0;
      r_c     <= 1'b0;
      r_t     <= 1'b0;
      r_o     <= c_idle;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_t     <= w_t_nxt;
      r_o     <= w_o_nxt;
    end
  end

  // Next-state decode for the switch sequence SELx -> DRAIN -> ARM -> SELy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_sel0, c_st_sel1: begin
        if (!w_sel_changed) begin
          w_state_nxt = r_state;
        end else if (c_is_async) begin
          // Immediate switch: hop straight to the newly selected source.
          w_state_nxt = S ? c_st_sel1 : c_st_sel0;
        end else begin
          w_state_nxt = c_st_drain;
        end
      end
      c_st_drain: begin
        if (!w_sel_changed) begin
          // Select reverted before the old source went idle; O never left
          // the old source, so resuming it is glitch-free.
          w_state_nxt = r_c ? c_st_sel1 : c_st_sel0;
        end else if (w_ic == c_idle) begin
          w_state_nxt = c_st_arm;
        end else begin
          w_state_nxt = c_st_drain;
        end
      end
      c_st_arm: begin
        if (w_tgt_changed) begin
          // Retarget while parked; keep waiting on the new target.
          w_state_nxt = c_st_arm;
        end else if (w_it == c_idle) begin
          // New source is at the idle level, so its next edge is a clean one.
          w_state_nxt = r_t ? c_st_sel1 : c_st_sel0;
        end else begin
          w_state_nxt = c_st_arm;
        end
      end
      default: begin
        w_state_nxt = c_st_sel0;
      end
    endcase
  end

  // Output and select-register updates that accompany each transition.
  always_comb begin
    w_o_nxt = r_o;
    w_c_nxt = r_c;
    w_t_nxt = r_t;
    case (r_state)
      c_st_sel0, c_st_sel1: begin
        if (!w_sel_changed) begin
          w_o_nxt = w_ic;
        end else if (c_is_async) begin
          w_c_nxt = S;
          w_t_nxt = S;
          w_o_nxt = w_is;
        end else begin
          // Old source keeps driving O for the cycle the request is seen.
          w_t_nxt = S;
          w_o_nxt = w_ic;
        end
      end
      c_st_drain: begin
        if (!w_sel_changed) begin
          w_t_nxt = r_c;
          w_o_nxt = w_ic;
        end else if (w_ic == c_idle) begin
          w_o_nxt = c_idle;
        end else begin
          w_o_nxt = w_ic;
        end
      end
      c_st_arm: begin
        // O is held at the idle level for the whole parked interval.
        w_o_nxt = c_idle;
        if (w_tgt_changed) begin
          w_t_nxt = S;
        end else if (w_it == c_idle) begin
          w_c_nxt = r_t;
        end
      end
      default: begin
        w_o_nxt = c_idle;
        w_c_nxt = 1'b0;
        w_t_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_x_bufgmux_ce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_bufgmux_ce
//  Description : Directed bench for x_bufgmux_ce. Three instances share the
//                stimulus: SYNC with L=0, SYNC with L=1, ASYNC with L=0.
//                Expected outputs for each step are queued when driven and
//                popped after the sampling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_bufgmux_ce;

  localparam logic [1:0] c_sel0  = 2'd0;
  localparam logic [1:0] c_sel1  = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_arm   = 2'd3;

  typedef struct packed {
    logic o0;
    logic o1;
    logic oa;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic i0    = 1'b0;
  logic i1    = 1'b0;
  logic s     = 1'b0;

  logic o_s0, sn_s0, o_s1, sn_s1, o_a, sn_a;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic a_left_sel = 1'b0;

  x_bufgmux_ce #(.CLK_SEL_TYPE(40'("SYNC")), .INIT_OUT(0)) dut_s0 (
    .CLK(clk), .RST_N(rst_n), .I0(i0), .I1(i1), .S(s), .O(o_s0), .SN(sn_s0)
  );
  x_bufgmux_ce #(.CLK_SEL_TYPE(40'("SYNC")), .INIT_OUT(1)) dut_s1 (
    .CLK(clk), .RST_N(rst_n), .I0(i0), .I1(i1), .S(s), .O(o_s1), .SN(sn_s1)
  );
  x_bufgmux_ce #(.CLK_SEL_TYPE(40'("ASYNC")), .INIT_OUT(0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .I0(i0), .I1(i1), .S(s), .O(o_a), .SN(sn_a)
  );

  always #5 clk = ~clk;

  // Flag any visit of the ASYNC instance to DRAIN or ARM (both have bit 1 set).
  always @(negedge clk) begin
    if (rst_n && dut_a.r_state[1]) a_left_sel = 1'b1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    if (exp !== 1'bx) begin
      n_cmp++;
      assert (obs === exp) else begin
        n_bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic rn, input logic v0,
                      input logic v1, input logic vs,
                      input logic e0, input logic e1, input logic ea);
    exp_t e;
    @(negedge clk);
    rst_n = rn; i0 = v0; i1 = v1; s = vs;
    q.push_back('{o0: e0, o1: e1, oa: ea});
    #1;
    chk1({tag, "_sn_s0"}, sn_s0, ~vs);
    chk1({tag, "_sn_s1"}, sn_s1, ~vs);
    chk1({tag, "_sn_a"},  sn_a,  ~vs);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk1({tag, "_o_s0"}, o_s0, e.o0);
    chk1({tag, "_o_s1"}, o_s1, e.o1);
    chk1({tag, "_o_a"},  o_a,  e.oa);
  endtask

  initial begin
    // Reset, both idle levels
    step("rst_a", 0, 0, 0, 0, 0, 1, 0);
    step("rst_b", 0, 0, 0, 0, 0, 1, 0);
    chk2("rst_state_s0", dut_s0.r_state, c_sel0);
    chk2("rst_state_s1", dut_s1.r_state, c_sel0);

    // Pass-through on I0
    step("pt1", 1, 1, 0, 0, 1, 1, 1);
    step("pt2", 1, 0, 0, 0, 0, 0, 0);
    step("pt3", 1, 1, 0, 0, 1, 1, 1);
    step("pt4", 1, 0, 0, 0, 0, 0, 0);

    // Glitch-free switch I0 -> I1
    step("sw_a", 1, 1, 1, 0, 1, 1, 1);
    step("sw_b", 1, 1, 1, 1, 1, 1, 1);
    chk2("sw_b_state_s0", dut_s0.r_state, c_drain);
    step("sw_c", 1, 1, 1, 1, 1, 1, 1);
    chk2("sw_c_state_s0", dut_s0.r_state, c_drain);
    chk2("sw_c_state_s1", dut_s1.r_state, c_arm);
    step("sw_d", 1, 0, 1, 1, 0, 1, 1);
    chk2("sw_d_state_s0", dut_s0.r_state, c_arm);
    chk2("sw_d_state_s1", dut_s1.r_state, c_sel1);
    step("sw_e", 1, 0, 1, 1, 0, 1, 1);
    step("sw_f", 1, 0, 0, 1, 0, 0, 0);
    chk2("sw_f_state_s0", dut_s0.r_state, c_sel1);
    step("sw_g", 1, 0, 1, 1, 1, 1, 1);
    step("sw_h", 1, 1, 0, 1, 0, 0, 0);

    // Revert while draining; ASYNC switch lands in one cycle
    step("rv_rst", 0, 1, 0, 0, 0, 1, 0);
    step("rv_a",   1, 1, 0, 0, 1, 1, 1);
    step("rv_b",   1, 1, 0, 1, 1, 1, 0);
    chk2("rv_b_state_s0", dut_s0.r_state, c_drain);
    chk2("rv_b_state_a",  dut_a.r_state,  c_sel1);
    step("rv_c",   1, 1, 0, 0, 1, 1, 1);
    chk2("rv_c_state_s0", dut_s0.r_state, c_sel0);
    step("rv_d",   1, 1, 0, 0, 1, 1, 1);

    // Reset while parked in ARM with L=1
    step("mr_a", 1, 0, 0, 1, 0, 0, 0);
    step("mr_b", 1, 1, 0, 1, 1, 1, 0);
    chk2("mr_b_state_s1", dut_s1.r_state, c_arm);
    step("mr_c", 1, 1, 0, 1, 1, 1, 0);
    chk2("mr_c_state_s1", dut_s1.r_state, c_arm);
    step("mr_d", 0, 0, 0, 1, 0, 1, 0);
    chk2("mr_d_state_s1", dut_s1.r_state, c_sel0);
    chk2("mr_d_c_s1", {1'b0, dut_s1.r_c}, 2'd0);

    // Release reset with S already high: ordinary switch from SEL0
    step("pr_a", 1, 0, 0, 1, 0, 0, 0);
    chk2("pr_a_state_s0", dut_s0.r_state, c_drain);
    step("pr_b", 1, 0, 1, 1, 0, 0, 1);
    chk2("pr_b_state_s0", dut_s0.r_state, c_arm);
    step("pr_c", 1, 0, 0, 1, 0, 0, 0);
    chk2("pr_c_state_s0", dut_s0.r_state, c_sel1);

    // X on the unselected input stays out of O
    step("xp_a", 1, 1'bx, 1, 1, 1, 1'bx, 1);
    step("xp_b", 1, 0, 1, 1, 1, 0, 1);

    // Retarget while parked in ARM (L=1 instance)
    step("rt_a", 1, 1, 1, 1, 1, 1, 1);
    chk2("rt_a_state_s1", dut_s1.r_state, c_arm);
    step("rt_b", 1, 1, 1, 0, 1, 1, 1);
    chk2("rt_b_state_s1", dut_s1.r_state, c_arm);
    chk2("rt_b_t_s1", {1'b0, dut_s1.r_t}, 2'd0);
    step("rt_c", 1, 1, 1, 0, 1, 1, 1);
    chk2("rt_c_state_s1", dut_s1.r_state, c_sel0);
    chk2("rt_c_state_s0", dut_s0.r_state, c_drain);

    chk1("async_never_drain_arm", a_left_sel, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_bufgmux_ce.md
X_BUFGMUX_CE -- requirements
Module: x_bufgmux_ce

Interface
REQ-001 SHALL have parameter CLK_SEL_TYPE, default "SYNC"; it sets the switch mode, "SYNC" for glitch-free and "ASYNC" for immediate.
REQ-002 SHALL have parameter INIT_OUT, default 0; it sets the idle level L of O. L=0 gives BUFGMUX behaviour and L=1 gives BUFGMUX_1 behaviour.
REQ-003 SHALL flag any CLK_SEL_TYPE outside {"SYNC","ASYNC"} or INIT_OUT outside {0,1} with an "Attribute Syntax Error" message at elaboration or time 0, then end simulation.
REQ-004 CLK  input  1  sampling clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset; synchronous, active-low.
REQ-006 I0  input  1  source 0, a clock-like signal sampled on CLK.
REQ-007 I1  input  1  source 1, a clock-like signal sampled on CLK.
REQ-008 S  input  1  select; 0 selects I0, 1 selects I1.
REQ-009 O  output  1  registered muxed output.
REQ-010 SN  output  1  combinational inverse of S (inverter function); SN = ~S at all times, with no reset dependence.

Function
REQ-011 SHALL implement a four-state FSM:
- SEL0 (following I0)
- SEL1 (following I1)
- DRAIN (old source still active)
- ARM (output parked at L, waiting on the new source)
REQ-012 SHALL register a target select T and a current select C; the "old source" is IC and the "new source" is IT.
REQ-013 In SELx with S==x: O <= Ix every cycle, giving a latency of 1 CLK from the sampled input to O.
REQ-014 SYNC, in SELx with S!=x: T <= S and go to DRAIN; O <= Ix in this cycle.
REQ-015 DRAIN: if IC==L, then O <= L and go to ARM; otherwise O <= IC and stay in DRAIN.
REQ-016 DRAIN with S==C again (select reverted before the old source idled): return to SEL(C), O <= IC; this path produces no glitch.
REQ-017 ARM: O <= L. If IT==L, go to SEL(T) and set C <= T; otherwise stay in ARM.
REQ-018 ARM with S!=T: T <= S and remain in ARM; O stays at L (retarget).
REQ-019 In SYNC mode, O SHALL never show a pulse shorter than the pulses on the source it passes; during a switch O is old-source, then L, then new-source, with no mixing.
REQ-020 ASYNC, in SELx with S!=x: go directly to SEL(S) and set C <= S; O <= I(S) in the same cycle. DRAIN and ARM are never entered.
REQ-021 An I0 or I1 X/Z value SHALL propagate to O only when that input is the one currently being passed.

Reset
REQ-022 When RST_N==0 at a CLK rising edge:
- state <= SEL0, C <= 0, T <= 0
- O <= INIT_OUT
REQ-023 Reset SHALL override any in-progress switch, including while the FSM is in DRAIN or ARM.
REQ-024 After reset release with S==1, the normal SYNC or ASYNC switch sequence from SEL0 SHALL follow, with no special case.
REQ-025 Before the first reset, O is X; the initial block SHALL NOT assign state.

Verification
REQ-026 Reset: INIT_OUT=0, RST_N=0 for 2 cycles -> O=0, state SEL0; INIT_OUT=1 under the same stimulus -> O=1.
REQ-027 Pass-through: SYNC, S=0, I0 toggling 1,0,1,0 on successive cycles -> O=1,0,1,0, each delayed 1 cycle; SN=1 throughout.
REQ-028 Glitch-free switch, L=0, SYNC:
- stimulus: I0=1 held 2 cycles, then 0; I1=1; S goes 0->1
- required: O stays 1 until I0 falls, then O=0 (ARM) until I1==0, then O follows I1
- O never toggles 1->0->1 within 1 cycle
REQ-029 Revert in DRAIN: S 0->1, then back to 0 one cycle later with I0 still 1 -> FSM returns to SEL0 and O stays 1 continuously.
REQ-030 ASYNC: S 0->1 with I0=1, I1=0 -> O=0 one cycle after S is sampled; DRAIN and ARM are never entered.
REQ-031 Reset mid-switch: assert RST_N=0 while the FSM is in ARM with L=1 -> next edge gives O=1, state SEL0, C=0.
